// File: rtl/aes_pkg.sv
// Shared constants, types and byte-level helpers for the iterative AES-128 inverse cipher.
package aes_pkg;

  localparam int NR    = 10;
  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUND  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Index 0 is the cipher key, index NR is the last round key.
  typedef logic [NR:0][BLK_W-1:0] round_keys_t;

  // Inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Request/response bundle of the inverse cipher; the master drives blocks in, the slave decrypts.
interface aes_inv_cipher_iter_if;
  import aes_pkg::*;

  // start is taken only on an edge where ready=1; a start seen while busy is dropped, not queued.
  logic              start;
  logic [BLK_W-1:0]  ciphertext;
  round_keys_t       round_keys;
  logic              cbc;
  logic              iv_load;
  logic [BLK_W-1:0]  iv;
  logic              ready;
  logic              busy;
  logic              done;
  logic [BLK_W-1:0]  plaintext;
  state_t            fsm;

  modport master (
    output start, ciphertext, round_keys, cbc, iv_load, iv,
    input  ready, busy, done, plaintext, fsm
  );

  modport slave (
    input  start, ciphertext, round_keys, cbc, iv_load, iv,
    output ready, busy, done, plaintext, fsm
  );

endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; last=1 drops InvMixColumns for round 0.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] blk,
  input  logic [BLK_W-1:0] rkey,
  input  logic             last,
  output logic [BLK_W-1:0] res
);

  logic [7:0] sb [16];
  logic [7:0] ak [16];
  logic [7:0] mc [16];

  function automatic logic [7:0] m9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] m11(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] m13(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] m14(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  // Byte 4*c+r is row r of column c; row r rotates right by r columns.
  always_comb begin
    sb  = '{default: '0};
    ak  = '{default: '0};
    mc  = '{default: '0};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[4*c+r] = inv_sbox(blk[BLK_W-1-8*(4*((c-r)&3)+r) -: 8]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      ak[i] = sb[i] ^ rkey[BLK_W-1-8*i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = m14(ak[4*c]) ^ m11(ak[4*c+1]) ^ m13(ak[4*c+2]) ^ m9(ak[4*c+3]);
      mc[4*c+1] = m9(ak[4*c])  ^ m14(ak[4*c+1]) ^ m11(ak[4*c+2]) ^ m13(ak[4*c+3]);
      mc[4*c+2] = m13(ak[4*c]) ^ m9(ak[4*c+1])  ^ m14(ak[4*c+2]) ^ m11(ak[4*c+3]);
      mc[4*c+3] = m11(ak[4*c]) ^ m13(ak[4*c+1]) ^ m9(ak[4*c+2])  ^ m14(ak[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      res[BLK_W-1-8*i -: 8] = last ? ak[i] : mc[i];
    end
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: UNROLL inverse rounds per cycle, optional CBC chaining.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter bit CBC_EN = 1'b1
)
(
  input logic clk,
  input logic rst,
  aes_inv_cipher_iter_if.slave bus
);

  state_t           state_q, state_d;
  logic [BLK_W-1:0] st, ct_q, chain, plaintext_q, round_out;
  logic [3:0]       rnd;
  logic             cbc_q, done_q;
  logic             ready, accept, last_cycle, finishing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FINISH also counts as ready so the next block can start on the Done edge.
  always_comb begin
    ready      = (state_q == IDLE) || (state_q == FINISH);
    accept     = ready && bus.start;
    finishing  = (state_q == FINISH);
    last_cycle = (rnd < 4'(UNROLL));
    state_d    = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (last_cycle) state_d = FINISH;
      FINISH:  state_d = accept ? ROUND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < UNROLL; k++) begin : g_rnd
    logic [BLK_W-1:0] src, res;
    logic [3:0]       idx;
    if (k == 0) begin : g_first
      assign src = st;
    end else begin : g_next
      assign src = g_rnd[k-1].res;
    end
    assign idx = rnd - 4'(k);
    aes_inv_round u_round (
      .blk  (src),
      .rkey (bus.round_keys[idx]),
      .last (idx == 4'd0),
      .res  (res)
    );
  end
  assign round_out = g_rnd[UNROLL-1].res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= '0;
      rnd         <= '0;
      ct_q        <= '0;
      cbc_q       <= 1'b0;
      plaintext_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= finishing;
      if (finishing) plaintext_q <= (CBC_EN && cbc_q) ? (st ^ chain) : st;
      if (accept) begin
        st    <= bus.ciphertext ^ bus.round_keys[NR];
        rnd   <= 4'(NR - 1);
        ct_q  <= bus.ciphertext;
        cbc_q <= CBC_EN ? bus.cbc : 1'b0;
      end else if (state_q == ROUND) begin
        st  <= round_out;
        rnd <= last_cycle ? 4'd0 : rnd - 4'(UNROLL);
      end
    end
  end

  // An Iv load wins over the chain update, and is what a block starting on the same edge uses.
  if (CBC_EN) begin : g_chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                       chain <= '0;
      else if (bus.iv_load && ready) chain <= bus.iv;
      else if (finishing && cbc_q)   chain <= ct_q;
    end
  end else begin : g_no_chain
    assign chain = '0;
  end

  assign bus.ready     = ready;
  assign bus.busy      = ~ready;
  assign bus.done      = done_q;
  assign bus.plaintext = plaintext_q;
  assign bus.fsm       = state_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 / SP800-38A vectors at UNROLL 1, 2, 5, 10.
module tb_aes_inv_cipher_iter;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [127:0]     ct    = '0;
  round_keys_t      rk    = '0;
  logic             cbc   = 1'b0;
  logic             iv_load = 1'b0;
  logic [127:0]     iv    = '0;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] ECB_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ECB_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ECB_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CBC_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CBC_IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CBC_C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC_P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CBC_C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CBC_P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic [2047:0] sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_inv_cipher_iter_if bus1 ();
  aes_inv_cipher_iter_if bus2 ();
  aes_inv_cipher_iter_if bus5 ();
  aes_inv_cipher_iter_if bus10 ();

  assign bus1.start  = start;   assign bus1.ciphertext  = ct; assign bus1.round_keys  = rk;
  assign bus1.cbc    = cbc;     assign bus1.iv_load     = iv_load; assign bus1.iv = iv;
  assign bus2.start  = start;   assign bus2.ciphertext  = ct; assign bus2.round_keys  = rk;
  assign bus2.cbc    = cbc;     assign bus2.iv_load     = iv_load; assign bus2.iv = iv;
  assign bus5.start  = start;   assign bus5.ciphertext  = ct; assign bus5.round_keys  = rk;
  assign bus5.cbc    = cbc;     assign bus5.iv_load     = iv_load; assign bus5.iv = iv;
  assign bus10.start = start;   assign bus10.ciphertext = ct; assign bus10.round_keys = rk;
  assign bus10.cbc   = cbc;     assign bus10.iv_load    = iv_load; assign bus10.iv = iv;

  aes_inv_cipher_iter #(.UNROLL(1),  .CBC_EN(1'b1)) dut     (.clk(clk), .rst(rst), .bus(bus1));
  aes_inv_cipher_iter #(.UNROLL(2),  .CBC_EN(1'b1)) dut_u2  (.clk(clk), .rst(rst), .bus(bus2));
  aes_inv_cipher_iter #(.UNROLL(5),  .CBC_EN(1'b1)) dut_u5  (.clk(clk), .rst(rst), .bus(bus5));
  aes_inv_cipher_iter #(.UNROLL(10), .CBC_EN(1'b1)) dut_u10 (.clk(clk), .rst(rst), .bus(bus10));

  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_flat[{~b, 3'b000} +: 8];
  endfunction

  function automatic round_keys_t expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    round_keys_t r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j <= 10; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  task automatic issue(input logic [127:0] c, input logic cb, input logic ivl,
                       input logic [127:0] ivv);
    @(posedge clk); #1;
    start = 1'b1; ct = c; cbc = cb; iv_load = ivl; iv = ivv;
    @(posedge clk); #1;
    start = 1'b0; iv_load = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int lat);
    lat = -1;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk); #1;
      if (bus1.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus1.ready); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus1.busy); end
    checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus1.done); end
    checks++; if (bus1.plaintext !== 128'h0) begin errors++; $display("FAIL reset_plaintext: got %h want 0", bus1.plaintext); end
    checks++; if (bus1.fsm !== IDLE) begin errors++; $display("FAIL reset_fsm: got %0d want %0d", bus1.fsm, IDLE); end
    checks++; if (dut.chain !== 128'h0) begin errors++; $display("FAIL reset_chain: got %h want 0", dut.chain); end
    checks++; if (dut.rnd !== 4'd0) begin errors++; $display("FAIL reset_rnd: got %0d want 0", dut.rnd); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_ecb();
    int lat;
    rk = expand_key(ECB_KEY);
    issue(ECB_CT, 1'b0, 1'b0, 128'h0);
    wait_done(20, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL ecb_latency: got %0d want 11", lat); end
    checks++; if (bus1.plaintext !== ECB_PT) begin errors++; $display("FAIL ecb_plaintext: got %h want %h", bus1.plaintext, ECB_PT); end
    @(posedge clk); #1;
    checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL ecb_done_pulse: got %b want 0", bus1.done); end
    checks++; if (bus1.plaintext !== ECB_PT) begin errors++; $display("FAIL ecb_hold: got %h want %h", bus1.plaintext, ECB_PT); end
  endtask

  task automatic test_unroll();
    int lat [4];
    logic [127:0] pt [4];
    int want [4];
    logic [3:0] d;
    want = '{11, 6, 3, 2};
    lat  = '{-1, -1, -1, -1};
    pt   = '{default: '0};
    rk = expand_key(ECB_KEY);
    issue(ECB_CT, 1'b0, 1'b0, 128'h0);
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      d = {bus10.done, bus5.done, bus2.done, bus1.done};
      if (d[0] && lat[0] < 0) begin lat[0] = n; pt[0] = bus1.plaintext; end
      if (d[1] && lat[1] < 0) begin lat[1] = n; pt[1] = bus2.plaintext; end
      if (d[2] && lat[2] < 0) begin lat[2] = n; pt[2] = bus5.plaintext; end
      if (d[3] && lat[3] < 0) begin lat[3] = n; pt[3] = bus10.plaintext; end
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (lat[i] != want[i]) begin errors++; $display("FAIL unroll_latency[%0d]: got %0d want %0d", i, lat[i], want[i]); end
      checks++; if (pt[i] !== ECB_PT) begin errors++; $display("FAIL unroll_plaintext[%0d]: got %h want %h", i, pt[i], ECB_PT); end
    end
  endtask

  task automatic test_cbc();
    int lat;
    rk = expand_key(CBC_KEY);
    issue(CBC_C1, 1'b1, 1'b1, CBC_IV);
    wait_done(20, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL cbc1_latency: got %0d want 11", lat); end
    checks++; if (bus1.plaintext !== CBC_P1) begin errors++; $display("FAIL cbc1_plaintext: got %h want %h", bus1.plaintext, CBC_P1); end
    checks++; if (bus10.plaintext !== CBC_P1) begin errors++; $display("FAIL cbc1_u10_plaintext: got %h want %h", bus10.plaintext, CBC_P1); end
    issue(CBC_C2, 1'b1, 1'b0, 128'h0);
    wait_done(20, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL cbc2_latency: got %0d want 11", lat); end
    checks++; if (bus1.plaintext !== CBC_P2) begin errors++; $display("FAIL cbc2_plaintext: got %h want %h", bus1.plaintext, CBC_P2); end
  endtask

  task automatic test_chain_priority();
    int lat;
    logic [127:0] raw;
    raw = CBC_P1 ^ CBC_IV;
    rk = expand_key(CBC_KEY);
    issue(CBC_C1, 1'b1, 1'b1, 128'h0);
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (n == 3) begin iv_load = 1'b1; iv = {128{1'b1}}; end
      if (n == 4) iv_load = 1'b0;
    end
    @(posedge clk); #1;
    checks++; if (bus1.ready !== 1'b1 || bus1.busy !== 1'b0) begin errors++; $display("FAIL finish_ready: got ready=%b busy=%b want 1/0", bus1.ready, bus1.busy); end
    iv_load = 1'b1; iv = CBC_IV;
    @(posedge clk); #1;
    iv_load = 1'b0;
    checks++; if (bus1.done !== 1'b1) begin errors++; $display("FAIL prio_done: got %b want 1", bus1.done); end
    checks++; if (bus1.plaintext !== raw) begin errors++; $display("FAIL busy_ivload_ignored: got %h want %h", bus1.plaintext, raw); end
    issue(CBC_C1, 1'b1, 1'b0, 128'h0);
    wait_done(20, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL prio_latency: got %0d want 11", lat); end
    checks++; if (bus1.plaintext !== CBC_P1) begin errors++; $display("FAIL ivload_over_chain: got %h want %h", bus1.plaintext, CBC_P1); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic exp_done, exp_ready;
    rk = expand_key(ECB_KEY);
    @(posedge clk); #1;
    start = 1'b1; ct = ECB_CT; cbc = 1'b0;
    @(posedge clk); #1;
    for (int n = 1; n <= 34; n++) begin
      @(posedge clk); #1;
      exp_done  = (n % 11 == 0);
      exp_ready = (n % 11 == 10);
      checks++; if (bus1.done !== exp_done) begin errors++; $display("FAIL b2b_done cyc %0d: got %b want %b", n, bus1.done, exp_done); end
      checks++; if (bus1.ready !== exp_ready || bus1.busy !== !exp_ready) begin errors++; $display("FAIL b2b_ready cyc %0d: got ready=%b busy=%b want ready=%b", n, bus1.ready, bus1.busy, exp_ready); end
      if (exp_done) begin
        checks++; if (bus1.plaintext !== ECB_PT) begin errors++; $display("FAIL b2b_plaintext cyc %0d: got %h want %h", n, bus1.plaintext, ECB_PT); end
      end
    end
    start = 1'b0;
    wait_done(20, lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL b2b_tail_latency: got %0d want 10", lat); end
  endtask

  task automatic test_mid_reset();
    int lat;
    rk = expand_key(ECB_KEY);
    issue(ECB_CT, 1'b0, 1'b0, 128'h0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (bus1.plaintext !== 128'h0) begin errors++; $display("FAIL midrst_plaintext: got %h want 0", bus1.plaintext); end
    checks++; if (bus1.ready !== 1'b1 || bus1.busy !== 1'b0) begin errors++; $display("FAIL midrst_ready: got ready=%b busy=%b want 1/0", bus1.ready, bus1.busy); end
    checks++; if (bus1.fsm !== IDLE) begin errors++; $display("FAIL midrst_fsm: got %0d want %0d", bus1.fsm, IDLE); end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      checks++; if (bus1.done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b want 0", bus1.done); end
    end
    rst = 1'b0;
    start = 1'b1; ct = ECB_CT; cbc = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, lat);
    checks++; if (lat != 11) begin errors++; $display("FAIL postrst_latency: got %0d want 11", lat); end
    checks++; if (bus1.plaintext !== ECB_PT) begin errors++; $display("FAIL postrst_plaintext: got %h want %h", bus1.plaintext, ECB_PT); end
  endtask

  initial begin
    test_reset();
    test_ecb();
    test_unroll();
    test_cbc();
    test_chain_priority();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Parameters
REQ-001 The block SHALL have parameter UNROLL, default 1, giving inverse rounds per cycle; legal values are 1, 2, 5 and 10.
REQ-002 The block SHALL have parameter CBC_EN, default 1; when 1, CBC chaining logic SHALL exist, and when 0 the Cbc input SHALL be ignored.

Interface
REQ-003 Clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request to decrypt one block; accepted only when Ready=1.
REQ-006 Ciphertext  input  128  block to decrypt; sampled on the accepted Start edge.
REQ-007 RoundKeys  input  11x128  precomputed schedule; index 0 is the cipher key and index 10 is the last round key; SHALL be held stable while Busy=1.
REQ-008 Cbc  input  1  chaining mode for the accepted block; sampled with Start.
REQ-009 IvLoad  input  1  loads Iv into the chaining register.
REQ-010 Iv  input  128  initialisation vector.
REQ-011 Ready  output  1  high when idle and able to accept Start.
REQ-012 Busy  output  1  high while a block is in flight.
REQ-013 Done  output  1  one-cycle pulse when Plaintext is updated.
REQ-014 Plaintext  output  128  registered result; held until the next Done.

Function
REQ-015 The FSM SHALL have states IDLE, ROUND and FINISH.
REQ-016 In IDLE with Start=1, the block SHALL load state with Ciphertext XOR RoundKeys[10], set round counter rnd to 9, latch Ciphertext and Cbc, and enter ROUND.
REQ-017 Each ROUND cycle SHALL apply UNROLL consecutive inverse rounds, combinationally chained, and decrement rnd by UNROLL.
REQ-018 For r >= 1, inverse round r SHALL be InvShiftRows, then InvSubBytes, then XOR RoundKeys[r], then InvMixColumns.
REQ-019 For r = 0, the inverse round SHALL be InvShiftRows, then InvSubBytes, then XOR RoundKeys[0], with no InvMixColumns.
REQ-020 After the cycle that applies round 0, the FSM SHALL enter FINISH.
REQ-021 In FINISH, Plaintext SHALL be registered and Done SHALL pulse for one cycle, after which the FSM returns to IDLE.
REQ-022 The registered Plaintext SHALL be: state XOR chain when the latched Cbc=1 and CBC_EN=1; otherwise state.
REQ-023 Latency from the accepting Start edge to the edge asserting Done SHALL be 10/UNROLL+1 cycles.
REQ-024 Ready SHALL be asserted in IDLE and in FINISH, so Start is accepted on the same edge Done is raised and no idle cycle is required between blocks.
REQ-025 Busy SHALL equal NOT Ready.
REQ-026 Start while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 Chain update: on each Done with latched Cbc=1, chain SHALL become the latched Ciphertext.
REQ-028 IvLoad=1 while Ready=1 SHALL load chain with Iv.
REQ-029 IvLoad=1 while Busy=1 SHALL be ignored.
REQ-030 If IvLoad and Start are accepted on the same edge, the newly loaded Iv SHALL be the chain value used for that block.
REQ-031 If IvLoad and a Done chain update coincide, IvLoad SHALL take priority.
REQ-032 The round counter rnd SHALL be 4 bits and SHALL never wrap below 0.
REQ-033 InvSubBytes SHALL be purely combinational, with no clocked S-box.

Reset
REQ-034 Reset=1 SHALL asynchronously force: FSM to IDLE, Ready=1, Busy=0, Done=0, Plaintext=0, chain=0, rnd=0.
REQ-035 Reset asserted mid-block SHALL abandon the block, produce no Done, and leave Plaintext=0.
REQ-036 Start on the first edge after Reset deasserts SHALL be accepted.

Structure
REQ-037 Package aes_pkg SHALL hold: NR=10, the block width constant 128, the FSM state enum, and the round-key array typedef.
REQ-038 The block SHALL contain one sub-module, aes_inv_round, with a "last" input that bypasses InvMixColumns, instantiated UNROLL times through a generate loop.

Verification
REQ-039 Scenario, ECB with UNROLL=1: RoundKeys from key 000102030405060708090a0b0c0d0e0f, Ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, Cbc=0 -> Plaintext 00112233445566778899aabbccddeeff, with Done exactly 11 cycles after Start.
REQ-040 Scenario, same ECB vector at UNROLL=2, 5 and 10 -> identical Plaintext, with Done latency of 6, 3 and 2 cycles respectively.
REQ-041 Scenario, CBC: key 2b7e151628aed2a6abf7158809cf4f3c, IvLoad with Iv 000102030405060708090a0b0c0d0e0f, Ciphertext 7649abac8119b246cee98e9b12e9197d -> Plaintext 6bc1bee22e409f96e93d7e117393172a; a second block SHALL then be chained off 7649abac8119b246cee98e9b12e9197d.
REQ-042 Scenario, handshake: Start held high continuously -> Start is ignored while Busy, and blocks run back-to-back with Done every 10/UNROLL+1 cycles.
REQ-043 Scenario, mid-block reset: Reset pulsed at round 5 -> Plaintext=0 with no Done, and the next Start yields the correct result.
REQ-044 Scenario, chaining priority: IvLoad during Busy is ignored; IvLoad on the Done edge overrides the chain update.
